// File: rtl/pbsw_pkg.sv
// Shared constants for the Nexys4 DDR pushbutton/switch conditioning block.
//
// Contents:
//   - Pushbutton bit positions inside the pbtn_in / pbtn_db vectors.
//   - Default prescaler divide and stability depth (1 ms ticks, 5 ticks).
//   - Width helpers used by the prescaler and the per-bit stability counters.
package pbsw_pkg;

  // Pushbutton bit order is {BTNC, BTNL, BTNU, BTNR, BTND, CPU_RESETN}.
  localparam int unsigned PB_RST = 0;
  localparam int unsigned PB_D   = 1;
  localparam int unsigned PB_R   = 2;
  localparam int unsigned PB_U   = 3;
  localparam int unsigned PB_L   = 4;
  localparam int unsigned PB_C   = 5;

  localparam int unsigned DEF_NUM_PB       = 6;
  localparam int unsigned DEF_NUM_SW       = 16;
  localparam int unsigned DEF_TICK_DIV     = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DEF_STABLE_TICKS = 5;

  // CPU_RESETN is active-low on the board, so its debounced level idles high.
  localparam logic [DEF_NUM_PB-1:0] DEF_PB_RESET_VAL = 6'b000001;

  // Counter has to hold 0..stable_ticks-1; one spare code keeps the width
  // non-zero even for stable_ticks == 1.
  function automatic int unsigned cnt_width(input int unsigned stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

  // Prescaler counts 0..div-1.
  function automatic int unsigned pre_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-bit debounce cell.
//
// The raw asynchronous level is brought through a 2-FF synchronizer, then
// compared against the current debounced level. While they disagree, the
// shared sample tick advances a small counter; after STABLE_TICKS consecutive
// disagreeing ticks the debounced level takes the synchronized value. Any cycle
// in which they agree clears the counter, so glitches shorter than one tick
// period can never flip the output. Registered rise/fall pulses follow one
// cycle after each change of the debounced level.
//
// Ports:
//   clk         system clock
//   SI_Reset_N  asynchronous active-low reset
//   tick        one-cycle sample strobe shared by all cells
//   raw         raw asynchronous input level
//   db_o        debounced level
//   rise_o      one-cycle pulse after db_o goes 0->1
//   fall_o      one-cycle pulse after db_o goes 1->0
module debounce_cell
  import pbsw_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic        RST_VAL      = 1'b0
) (
  input  logic clk,
  input  logic SI_Reset_N,
  input  logic tick,
  input  logic raw,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned          CntW    = cnt_width(STABLE_TICKS);
  localparam logic [CntW-1:0]      CntLast = CntW'(STABLE_TICKS - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            db_prev_q, db_prev_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    db_d      = db_q;

    if (sync2_q == db_q) begin
      // Agreement at any moment restarts qualification.
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CntLast) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Edge pulses are taken from the registered level, so they appear the
    // cycle after db_o moves and last exactly one cycle.
    db_prev_d = db_q;
    rise_d    = db_q & ~db_prev_q;
    fall_d    = ~db_q & db_prev_q;
  end

  // Sync and history flops reset to the debounced reset value so leaving
  // reset never looks like a mismatch or an edge.
  always_ff @(posedge clk or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      sync1_q   <= RST_VAL;
      sync2_q   <= RST_VAL;
      cnt_q     <= '0;
      db_q      <= RST_VAL;
      db_prev_q <= RST_VAL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pbsw_debouncer.sv
// Pushbutton / slide-switch conditioner for the Nexys4 DDR board.
//
// A free-running prescaler produces a one-cycle sample tick every TICK_DIV
// clocks; every pushbutton and switch bit has its own debounce_cell sharing
// that tick. Debounced levels feed the GPIO, bot config and system reset;
// pushbuttons additionally get registered rise/fall pulses.
// TICK_DIV must be >= 2 and STABLE_TICKS >= 1.
//
// Ports:
//   clk          system clock (clk_out_50)
//   SI_Reset_N   asynchronous active-low reset
//   pbtn_in      raw pushbuttons {BTNC, BTNL, BTNU, BTNR, BTND, CPU_RESETN}
//   switch_in    raw slide switches
//   pbtn_db      debounced pushbuttons
//   swtch_db     debounced switches
//   pbtn_rise    one-cycle pulse after a pbtn_db bit goes 0->1
//   pbtn_fall    one-cycle pulse after a pbtn_db bit goes 1->0
//   sample_tick  prescaler tick, high while the prescaler sits at TICK_DIV-1
module pbsw_debouncer
  import pbsw_pkg::*;
#(
  parameter int unsigned       NUM_PB       = DEF_NUM_PB,
  parameter int unsigned       NUM_SW       = DEF_NUM_SW,
  parameter int unsigned       TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned       STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic [NUM_PB-1:0] PB_RESET_VAL = DEF_PB_RESET_VAL
) (
  input  logic              clk,
  input  logic              SI_Reset_N,
  input  logic [NUM_PB-1:0] pbtn_in,
  input  logic [NUM_SW-1:0] switch_in,
  output logic [NUM_PB-1:0] pbtn_db,
  output logic [NUM_SW-1:0] swtch_db,
  output logic [NUM_PB-1:0] pbtn_rise,
  output logic [NUM_PB-1:0] pbtn_fall,
  output logic              sample_tick
);

  localparam int unsigned     PreW    = pre_width(TICK_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick;

  // Tick decodes straight from the prescaler register, so it is glitch-free
  // and has no path from any input.
  assign tick = (pre_q == PreLast);

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign sample_tick = tick;

  for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
    debounce_cell #(
      .STABLE_TICKS (STABLE_TICKS),
      .RST_VAL      (PB_RESET_VAL[i])
    ) u_cell (
      .clk        (clk),
      .SI_Reset_N (SI_Reset_N),
      .tick       (tick),
      .raw        (pbtn_in[i]),
      .db_o       (pbtn_db[i]),
      .rise_o     (pbtn_rise[i]),
      .fall_o     (pbtn_fall[i])
    );
  end

  // Switches need levels only; their edge outputs are left dangling and
  // optimise away.
  logic [NUM_SW-1:0] sw_rise_unused;
  logic [NUM_SW-1:0] sw_fall_unused;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_cell #(
      .STABLE_TICKS (STABLE_TICKS),
      .RST_VAL      (1'b0)
    ) u_cell (
      .clk        (clk),
      .SI_Reset_N (SI_Reset_N),
      .tick       (tick),
      .raw        (switch_in[i]),
      .db_o       (swtch_db[i]),
      .rise_o     (sw_rise_unused[i]),
      .fall_o     (sw_fall_unused[i])
    );
  end

endmodule

// File: tb/tb_pbsw_debouncer.sv
// Scoreboard bench for pbsw_debouncer with TICK_DIV=4, STABLE_TICKS=3.
// The driver advances a tick-count reference model once per clock and queues
// the expected outputs; a negedge monitor pops and compares them.
module tb_pbsw_debouncer;

  localparam int NB = 22;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam logic [5:0]    PB_RST  = 6'b000001;
  localparam logic [NB-1:0] RST_VEC = {16'h0000, 6'b000001};

  logic        clk = 1'b0;
  logic        SI_Reset_N;
  logic [5:0]  pbtn_in;
  logic [15:0] switch_in;
  logic [5:0]  pbtn_db;
  logic [15:0] swtch_db;
  logic [5:0]  pbtn_rise;
  logic [5:0]  pbtn_fall;
  logic        sample_tick;

  always #5 clk = ~clk;

  pbsw_debouncer #(
    .NUM_PB       (6),
    .NUM_SW       (16),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .PB_RESET_VAL (6'b000001)
  ) dut (
    .clk         (clk),
    .SI_Reset_N  (SI_Reset_N),
    .pbtn_in     (pbtn_in),
    .switch_in   (switch_in),
    .pbtn_db     (pbtn_db),
    .swtch_db    (swtch_db),
    .pbtn_rise   (pbtn_rise),
    .pbtn_fall   (pbtn_fall),
    .sample_tick (sample_tick)
  );

  typedef struct packed {
    logic [5:0]  db;
    logic [15:0] sw;
    logic [5:0]  rise;
    logic [5:0]  fall;
    logic        tick;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   vectors     = 0;
  int   miscompares = 0;
  int   mon_cycle   = 0;
  int   sw3_changes = 0;
  logic sw3_last    = 1'b0;

  // Reference model: edge e counts clocks since reset release. The debounced
  // level a bit sees at edge e is the raw level two edges earlier. Ticks land
  // on edges that are multiples of TD; a bit flips at the tick edge where its
  // unbroken disagreement run has spanned ST ticks.
  int            e;
  logic [NB-1:0] hist[$];
  logic [NB-1:0] d_cur, d_prev;
  int            mis_start[NB];
  logic [5:0]    m_rise, m_fall;

  task automatic model_reset();
    e = 0;
    hist.delete();
    d_cur  = RST_VEC;
    d_prev = RST_VEC;
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < NB; b++) mis_start[b] = -1;
  endtask

  task automatic model_edge();
    logic [NB-1:0] s, nd;
    e++;
    hist.push_back({switch_in, pbtn_in});
    s  = (e >= 3) ? hist[e-3] : RST_VEC;
    nd = d_cur;
    for (int b = 0; b < NB; b++) begin
      if (s[b] == d_cur[b]) begin
        mis_start[b] = -1;
      end else begin
        if (mis_start[b] < 0) mis_start[b] = e;
        if ((e % TD == 0) && ((e / TD) - ((mis_start[b] - 1) / TD) >= ST)) begin
          nd[b]        = s[b];
          mis_start[b] = -1;
        end
      end
    end
    m_rise = d_cur[5:0] & ~d_prev[5:0];
    m_fall = ~d_cur[5:0] & d_prev[5:0];
    d_prev = d_cur;
    d_cur  = nd;
  endtask

  task automatic cyc(input logic [5:0] pb, input logic [15:0] sw, input logic rn);
    exp_t x;
    @(posedge clk);
    if (SI_Reset_N) model_edge();
    #1;
    pbtn_in    = pb;
    switch_in  = sw;
    SI_Reset_N = rn;
    if (!rn) model_reset();
    x.db   = d_cur[5:0];
    x.sw   = d_cur[21:6];
    x.rise = m_rise;
    x.fall = m_fall;
    x.tick = rn && (e % TD == TD - 1);
    exp_q.push_back(x);
  endtask

  task automatic check(input string nm, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic check_range(input string nm, input int got, input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d..%0d", nm, got, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    mon_cycle++;
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      vectors++;
      if (pbtn_db !== mon_x.db || swtch_db !== mon_x.sw || pbtn_rise !== mon_x.rise ||
          pbtn_fall !== mon_x.fall || sample_tick !== mon_x.tick) begin
        miscompares++;
        $display("FAIL outputs@%0d: got db=%b sw=%h rise=%b fall=%b tick=%b required db=%b sw=%h rise=%b fall=%b tick=%b",
                 mon_cycle, pbtn_db, swtch_db, pbtn_rise, pbtn_fall, sample_tick,
                 mon_x.db, mon_x.sw, mon_x.rise, mon_x.fall, mon_x.tick);
      end
    end
    if (swtch_db[3] !== sw3_last) sw3_changes++;
    sw3_last = swtch_db[3];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Apply a pushbutton change and check latency plus the following edge pulse.
  task automatic press_test(input logic [5:0] pb, input logic level, input string nm);
    int n;
    cyc(pb, 16'h0000, 1);
    n = 0;
    while (pbtn_db[5] !== level && n < 30) begin
      cyc(pb, 16'h0000, 1);
      n++;
    end
    check_range({nm, "_latency"}, n, 11, 15);
    cyc(pb, 16'h0000, 1);
    check({nm, "_pulse"}, level ? int'(pbtn_rise[5]) : int'(pbtn_fall[5]), 1);
    cyc(pb, 16'h0000, 1);
    check({nm, "_pulse_width"}, level ? int'(pbtn_rise[5]) : int'(pbtn_fall[5]), 0);
    repeat (5) cyc(pb, 16'h0000, 1);
  endtask

  initial begin
    int          n, k, ticks;
    logic [5:0]  pbv, inv_pb;
    logic [15:0] swv;

    SI_Reset_N = 1'b0;
    pbtn_in    = PB_RST;
    switch_in  = '0;
    model_reset();

    // Reset and quiet idle
    repeat (3) cyc(PB_RST, 16'h0000, 0);
    check("reset_pbtn_db", int'(pbtn_db), int'(PB_RST));
    check("reset_swtch_db", int'(swtch_db), 0);
    repeat (20) cyc(PB_RST, 16'h0000, 1);

    // Clean press and release of BTNC
    press_test(PB_RST | 6'b100000, 1'b1, "press");
    press_test(PB_RST, 1'b0, "release");

    // Bounce on switch 3
    sw3_changes = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(PB_RST, (((i / 3) % 2) == 0) ? 16'h0008 : 16'h0000, 1);
    end
    check("bounce_held_low", int'(swtch_db[3]), 0);
    cyc(PB_RST, 16'h0008, 1);
    n = 0;
    while (swtch_db[3] !== 1'b1 && n < 30) begin
      cyc(PB_RST, 16'h0008, 1);
      n++;
    end
    check_range("bounce_latency", n + 1, 1, 15);
    repeat (5) cyc(PB_RST, 16'h0008, 1);
    check("bounce_transitions", sw3_changes, 1);

    // One-cycle glitch on BTNR
    cyc(PB_RST | 6'b000100, 16'h0008, 1);
    cyc(PB_RST, 16'h0008, 1);
    repeat (20) cyc(PB_RST, 16'h0008, 1);
    check("glitch_db2", int'(pbtn_db[2]), 0);

    // Reset in the middle of qualification
    repeat (2) cyc(PB_RST, 16'h0000, 0);
    cyc(PB_RST, 16'hFFFF, 1);
    k = 0;
    ticks = 0;
    while (ticks < 2 && k < 20) begin
      cyc(PB_RST, 16'hFFFF, 1);
      k++;
      if (sample_tick) ticks++;
    end
    check("midreset_ticks_seen", ticks, 2);
    check("midreset_not_flipped", int'(swtch_db), 0);
    cyc(PB_RST, 16'hFFFF, 0);
    check("midreset_cleared", int'(swtch_db), 0);
    cyc(PB_RST, 16'hFFFF, 0);
    cyc(PB_RST, 16'hFFFF, 1);
    n = 0;
    while (swtch_db !== 16'hFFFF && n < 30) begin
      cyc(PB_RST, 16'hFFFF, 1);
      n++;
    end
    check_range("midreset_requalify", n, 11, 15);
    repeat (5) cyc(PB_RST, 16'hFFFF, 1);

    // Everything inverted on one edge
    inv_pb = ~PB_RST;
    cyc(inv_pb, 16'h0000, 1);
    n = 0;
    while (pbtn_db !== inv_pb && n < 30) begin
      cyc(inv_pb, 16'h0000, 1);
      n++;
    end
    check_range("simul_latency", n, 11, 15);
    check("simul_sw_same_clock", int'(swtch_db), 0);
    repeat (5) cyc(inv_pb, 16'h0000, 1);

    // Randomized traffic with glitches, multi-bit flips and a reset
    pbv = inv_pb;
    swv = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (i == 700) begin
        repeat (2) cyc(pbv, swv, 0);
      end else if (r == 0) begin
        pbv[$urandom_range(0, 5)] ^= 1'b1;
        cyc(pbv, swv, 1);
      end else if (r == 1) begin
        swv[$urandom_range(0, 15)] ^= 1'b1;
        cyc(pbv, swv, 1);
      end else if (r == 2) begin
        cyc(pbv ^ 6'(1 << $urandom_range(0, 5)), swv ^ 16'(1 << $urandom_range(0, 15)), 1);
      end else if (r == 3 && $urandom_range(0, 3) == 0) begin
        pbv ^= 6'($urandom);
        swv ^= 16'($urandom);
        cyc(pbv, swv, 1);
      end else begin
        cyc(pbv, swv, 1);
      end
    end
    repeat (40) cyc(pbv, swv, 1);

    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pbsw_debouncer.md
Name: pbsw_debouncer

Overview:
- Conditions the raw Nexys4 DDR pushbuttons and slide switches before they reach the system.
- Covers BTNC, BTNL, BTNU, BTNR, BTND, CPU_RESETN and SW[15:0].
- Each input passes through a 2-FF synchronizer, then a shared-tick stability filter.
- Outputs:
  - debounced levels, which feed the IO_PB / IO_Switch GPIO, Bot_Config_reg and the system reset;
  - one-cycle rise/fall pulses for software-free edge detection.
- Sits directly upstream of mfp_sys and rojobot31_0, in the 50 MHz domain.

Parameters:
- NUM_PB, 6, pushbutton width. Bit order {BTNC, BTNL, BTNU, BTNR, BTND, CPU_RESETN}.
- NUM_SW, 16, slide-switch width.
- TICK_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz). Must be ≥2.
- STABLE_TICKS, 5, consecutive mismatching ticks required before an output flips. Must be ≥1.
- PB_RESET_VAL, 6'b000001, reset value of pbtn_db. CPU_RESETN idles high.

Ports:
- clk  in  1  system clock (clk_out_50).
- SI_Reset_N  in  1  asynchronous active-low reset.
- pbtn_in  in  NUM_PB  raw pushbutton levels, asynchronous.
- switch_in  in  NUM_SW  raw switch levels, asynchronous.
- pbtn_db  out  NUM_PB  debounced pushbutton levels.
- swtch_db  out  NUM_SW  debounced switch levels.
- pbtn_rise  out  NUM_PB  one-cycle pulse when pbtn_db bit goes 0→1.
- pbtn_fall  out  NUM_PB  one-cycle pulse when pbtn_db bit goes 1→0.
- sample_tick  out  1  prescaler tick, for debug and bench use.

Behaviour:
- Reset (SI_Reset_N=0, asynchronous):
  - pbtn_db=PB_RESET_VAL, swtch_db=0, pbtn_rise=0, pbtn_fall=0, sample_tick=0.
  - Prescaler=0, all stability counters=0.
  - Sync flops reset to the matching db reset value, so there is no spurious mismatch.
- Prescaler: counts 0..TICK_DIV-1 and wraps. sample_tick=1 for exactly the one cycle in which count==TICK_DIV-1.
- Per bit, let s be the 2-FF synchronized value and d the debounced output.
  - s==d: counter cleared to 0 on that clock, regardless of tick. A glitch shorter than one tick period therefore never flips d.
  - s!=d and tick, counter<STABLE_TICKS-1: counter+1.
  - s!=d and tick, counter==STABLE_TICKS-1: d<=s and counter<=0 on the same edge.
  - s!=d and no tick: counter holds.
- Latency from a clean input edge to the d change: between (STABLE_TICKS-1)*TICK_DIV+3 and STABLE_TICKS*TICK_DIV+3 clk cycles.
- Counter width: $clog2(STABLE_TICKS+1). The counter never exceeds STABLE_TICKS-1, so it cannot wrap.
- Edge pulses:
  - pbtn_rise/pbtn_fall are registered. They are asserted the cycle after d changes, for exactly 1 cycle.
  - Rise and fall are never both asserted on the same bit.
- Simultaneous flips on several bits are independent; each has its own counter. All share the same tick.
- Input toggling back to d before the flip: the counter clears, no output change.
- Reset mid-count: counters are discarded. After release, d resumes from its reset value, and a held input re-qualifies over the full STABLE_TICKS.
- No combinational path from any input to any output.

Decomposition:
- Shared package pbsw_pkg:
  - PB index constants: PB_RST=0, PB_D=1, PB_R=2, PB_U=3, PB_L=4, PB_C=5.
  - Default TICK_DIV / STABLE_TICKS values.
- Sub-module debounce_cell: one bit, containing sync flops, counter, d flop and edge flops. Inputs are clk, SI_Reset_N, tick, raw. Parameter RST_VAL.
- Top: prescaler plus a generate loop of NUM_PB+NUM_SW debounce_cell instances. Switch cells tie off the edge outputs.

Test Plan (TICK_DIV=4, STABLE_TICKS=3):
- Reset:
  - Stimulus: hold SI_Reset_N=0, then release, with pbtn_in=6'b000001 and switch_in=0.
  - Required: pbtn_db=6'b000001, swtch_db=0, no rise/fall pulse ever. sample_tick first asserted 4 cycles after release, then every 4 cycles.
- Clean press:
  - Stimulus: pbtn_in[5] 0→1 and held.
  - Required: pbtn_db[5]=1 within 11–15 cycles. pbtn_rise[5]=1 for exactly the following cycle. Release produces pbtn_fall[5] with the same timing.
- Bounce:
  - Stimulus: switch_in[3] toggles every 3 cycles for 30 cycles, then holds 1.
  - Required: swtch_db[3] stays 0 throughout the toggling, then goes 1 within 15 cycles of the hold starting. Exactly one transition.
- Glitch:
  - Stimulus: a 1-cycle pulse on pbtn_in[2].
  - Required: pbtn_db[2] unchanged, no pulses.
- Mid-count reset:
  - Stimulus: switch_in=16'hFFFF; assert SI_Reset_N=0 for 2 cycles after the 2nd tick.
  - Required: swtch_db=0 immediately. It reaches 16'hFFFF only 11–15 cycles after release.
- Simultaneous:
  - Stimulus: all pbtn bits and switch bits inverted on one edge.
  - Required: every output flips on the same clock.
